decode_buffer: RTL and testbench
================================

# decode_buffer

Instruction decode buffer that sits directly downstream of the fetch stage. It captures each fetched 16-bit instruction together with its PC, splits it into fields, and presents the fields to the execute stage through a valid/ready handshake. A two-entry skid buffer absorbs back-pressure so that fetch sees a registered ready. A flush input discards in-flight instructions after a taken branch or jump.

## Interface
- DATA_W, 16, instruction and PC width (fixed at 16 in this design)
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- inst  in  16  instruction word from fetch
- pc  in  16  PC of `inst`
- in_valid  in  1  `inst`/`pc` carry a real instruction this cycle
- in_ready  out  1  buffer can accept; registered, equals !skid_valid
- flush  in  1  discard all held instructions and the current input
- out_valid  out  1  decoded fields below are valid
- out_ready  in  1  execute stage consumes this cycle
- out_pc  out  16  PC of the presented instruction
- out_inst  out  16  raw instruction word
- opcode  out  4  out_inst[15:12]
- rd  out  4  out_inst[11:8]
- rs  out  4  out_inst[7:4]
- rt  out  4  out_inst[3:0]
- imm  out  16  out_inst[7:0], sign-extended (bit 7 replicated into [15:8])

## Operation
- Storage consists of two slots, each holding {pc, inst, valid}:
  - main slot, which drives the outputs;
  - skid slot, which is filled only when main is valid and stalled.
- Accept: `in_valid && in_ready && !flush`.
- Consume: `out_valid && out_ready`.
- Per-edge rules (when not flushing):
  - main empty or consumed, skid empty: an accepted input loads main; otherwise main.valid <= 0.
  - main empty or consumed, skid full: skid moves to main, skid.valid <= 0. in_ready was 0, so no accept is possible.
  - main full and not consumed, skid empty: an accepted input loads skid.
  - main full and not consumed, skid full: hold. in_ready is 0.
- Fields are pure combinational slices of the main slot. No decode state lives outside the slots.
- Order is strictly FIFO. No instruction is duplicated or dropped except by flush.
- Flush has priority over every other event:
  - next edge: main.valid <= 0 and skid.valid <= 0;
  - input offered in the flush cycle is not accepted;
  - a consume in the flush cycle still counts as consumed by execute.
- Reset: main and skid valid = 0, all data registers = 0.
  - Outputs after reset: out_valid=0, in_ready=1, out_pc=0, out_inst=0, opcode=rd=rs=rt=0, imm=0.
  - Reset asserted mid-operation discards all held instructions immediately, asynchronously.

## Timing
- Latency: an input accepted at edge N is presented with out_valid=1 after edge N.
- Throughput: 1 instruction/cycle while out_ready stays high.
- Back-pressure:
  - After out_ready drops, the buffer accepts at most one more instruction (into skid). in_ready falls after that edge.
  - in_ready rises the cycle after skid drains.
- Fetch must hold inst/pc stable while in_valid && !in_ready. Fetch's PC advance is gated by in_ready at top level.
- out_* change only on clock edges (or on reset); nothing combinational from the inputs reaches the outputs.
- flush is sampled only at the clock edge. out_valid is 0 in the cycle after a flush edge unless reset intervenes.

## Test plan
- Reset, then stream inst=0x1234,0x5678,0x9ABC at pc=0,1,2 with out_ready=1 -> after each following edge: opcode=1,rd=2,rs=3,rt=4,imm=0x0034; then 5,6,7,8,imm=0x0078; then 9,A,B,C,imm=0xFFBC; out_pc 0,1,2.
- Back-pressure: hold out_ready=0 while offering 3 instructions -> first in main, second in skid, in_ready=0 on the third. Raise out_ready -> all 3 emerge in order with no gaps, and in_ready returns 1 one cycle after skid drains.
- Flush with both slots full and in_valid=1 -> next cycle out_valid=0 and in_ready=1. The flushed-cycle input never appears at the output.
- Simultaneous consume and accept with skid empty -> main is replaced in one cycle with no bubble, and skid stays empty.
- Assert rst mid-stream between edges -> out_valid=0, in_ready=1, and all fields 0 immediately. After rst drops, the next accepted instruction appears normally.
- Sign-extension boundary: inst=0x007F -> imm=0x007F; inst=0x0080 -> imm=0xFF80.

Source files
------------

// File: rtl/decode_buffer.sv
// Purpose : decode buffer between fetch and execute; holds {pc, inst} in a main slot
//           plus a skid slot and presents the instruction fields combinationally from main.
// Latency : an input accepted at edge N is presented (out_valid=1) right after edge N.
// Backpr. : in_ready is registered (= !skid_valid); one extra instruction lands in skid after out_ready drops.
// Ports   : clk/rst (async, active-high); inst/pc/in_valid/in_ready from fetch; flush drops
//           everything held plus the current input; out_valid/out_ready handshake to execute;
//           out_pc/out_inst/opcode/rd/rs/rt/imm are slices of the main slot.
module decode_buffer #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] inst,
   input  logic [DATA_W-1:0] pc,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_inst,
   output logic [3:0]        opcode,
   output logic [3:0]        rd,
   output logic [3:0]        rs,
   output logic [3:0]        rt,
   output logic [DATA_W-1:0] imm
);

   logic              main_valid;
   logic [DATA_W-1:0] main_pc;
   logic [DATA_W-1:0] main_inst;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_pc;
   logic [DATA_W-1:0] skid_inst;

   logic accept;
   logic main_free;

   // in_ready comes straight from a flop, so fetch never sees a combinational path from out_ready.
   assign in_ready  = !skid_valid;
   assign accept    = in_valid && in_ready && !flush;
   // Main can take new content when it is empty or being consumed this cycle.
   assign main_free = !main_valid || out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         main_pc    <= '0;
         main_inst  <= '0;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_inst  <= '0;
      end else if (flush) begin
         // A consume in this cycle still happened on the execute side; nothing is replayed.
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_free) begin
         if (skid_valid) begin
            // Skid is older than anything fetch can offer now (in_ready was 0), so it goes first.
            main_valid <= 1'b1;
            main_pc    <= skid_pc;
            main_inst  <= skid_inst;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_valid <= 1'b1;
            main_pc    <= pc;
            main_inst  <= inst;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         // Main is stalled; accept is only possible with skid empty.
         skid_valid <= 1'b1;
         skid_pc    <= pc;
         skid_inst  <= inst;
      end
   end

   assign out_valid = main_valid;
   assign out_pc    = main_pc;
   assign out_inst  = main_inst;
   assign opcode    = main_inst[15:12];
   assign rd        = main_inst[11:8];
   assign rs        = main_inst[7:4];
   assign rt        = main_inst[3:0];
   assign imm       = {{(DATA_W-8){main_inst[7]}}, main_inst[7:0]};

endmodule

// File: tb/tb_decode_buffer.sv
module tb_decode_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] inst;
   logic [15:0] pc;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_pc;
   logic [15:0] out_inst;
   logic [3:0]  opcode;
   logic [3:0]  rd;
   logic [3:0]  rs;
   logic [3:0]  rt;
   logic [15:0] imm;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   decode_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .inst      (inst),
      .pc        (pc),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .opcode    (opcode),
      .rd        (rd),
      .rs        (rs),
      .rt        (rt),
      .imm       (imm)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle 1ns past it before checking or driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [15:0] i, input logic [15:0] p);
      in_valid = v;
      inst     = i;
      pc       = p;
   endtask

   // Expect a valid instruction at the output; field values are hand-given by the caller.
   task automatic chk_out(input string tag, input logic [15:0] ei, input logic [15:0] ep,
                          input logic [3:0] eop, input logic [3:0] erd, input logic [3:0] ers,
                          input logic [3:0] ert, input logic [15:0] eimm);
      chk({tag, ".out_valid"}, {15'd0, out_valid}, 16'd1);
      chk({tag, ".out_inst"},  out_inst, ei);
      chk({tag, ".out_pc"},    out_pc, ep);
      chk({tag, ".opcode"},    {12'd0, opcode}, {12'd0, eop});
      chk({tag, ".rd"},        {12'd0, rd}, {12'd0, erd});
      chk({tag, ".rs"},        {12'd0, rs}, {12'd0, ers});
      chk({tag, ".rt"},        {12'd0, rt}, {12'd0, ert});
      chk({tag, ".imm"},       imm, eimm);
   endtask

   task automatic chk_idle_reset(input string tag);
      chk({tag, ".out_valid"}, {15'd0, out_valid}, 16'd0);
      chk({tag, ".in_ready"},  {15'd0, in_ready}, 16'd1);
      chk({tag, ".out_pc"},    out_pc, 16'h0000);
      chk({tag, ".out_inst"},  out_inst, 16'h0000);
      chk({tag, ".fields"},    {opcode, rd, rs, rt}, 16'h0000);
      chk({tag, ".imm"},       imm, 16'h0000);
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      offer(1'b0, 16'h0000, 16'h0000);
      step();
      step();
      chk_idle_reset("reset");
      rst = 1'b0;
      step();
      chk_idle_reset("post_reset_idle");

      // Streaming at full throughput.
      out_ready = 1'b1;
      offer(1'b1, 16'h1234, 16'd0);
      step();
      chk_out("s0", 16'h1234, 16'd0, 4'h1, 4'h2, 4'h3, 4'h4, 16'h0034);
      offer(1'b1, 16'h5678, 16'd1);
      step();
      chk_out("s1", 16'h5678, 16'd1, 4'h5, 4'h6, 4'h7, 4'h8, 16'h0078);
      offer(1'b1, 16'h9ABC, 16'd2);
      step();
      chk_out("s2", 16'h9ABC, 16'd2, 4'h9, 4'hA, 4'hB, 4'hC, 16'hFFBC);
      chk("s2.in_ready", {15'd0, in_ready}, 16'd1);
      offer(1'b0, 16'h0000, 16'd0);
      step();
      chk("s_drain.out_valid", {15'd0, out_valid}, 16'd0);

      // Back-pressure: A to main, B to skid, C refused.
      out_ready = 1'b0;
      offer(1'b1, 16'h1111, 16'd10);
      step();
      chk("bp_a.out_inst", out_inst, 16'h1111);
      chk("bp_a.in_ready", {15'd0, in_ready}, 16'd1);
      offer(1'b1, 16'h2222, 16'd11);
      step();
      chk("bp_b.out_inst", out_inst, 16'h1111);
      chk("bp_b.in_ready", {15'd0, in_ready}, 16'd0);
      offer(1'b1, 16'h3333, 16'd12);
      step();
      chk("bp_hold.out_inst", out_inst, 16'h1111);
      chk("bp_hold.out_pc", out_pc, 16'd10);
      chk("bp_hold.in_ready", {15'd0, in_ready}, 16'd0);
      out_ready = 1'b1;
      step();
      chk_out("bp_out_b", 16'h2222, 16'd11, 4'h2, 4'h2, 4'h2, 4'h2, 16'h0022);
      chk("bp_out_b.in_ready", {15'd0, in_ready}, 16'd1);
      step();
      chk_out("bp_out_c", 16'h3333, 16'd12, 4'h3, 4'h3, 4'h3, 4'h3, 16'h0033);
      offer(1'b0, 16'h0000, 16'd0);
      step();
      chk("bp_end.out_valid", {15'd0, out_valid}, 16'd0);

      // Flush with both slots full and an input offered.
      out_ready = 1'b0;
      offer(1'b1, 16'h4444, 16'd20);
      step();
      offer(1'b1, 16'h5555, 16'd21);
      step();
      chk("fl_full.in_ready", {15'd0, in_ready}, 16'd0);
      flush = 1'b1;
      offer(1'b1, 16'h6666, 16'd22);
      step();
      flush = 1'b0;
      chk("fl.out_valid", {15'd0, out_valid}, 16'd0);
      chk("fl.in_ready", {15'd0, in_ready}, 16'd1);
      offer(1'b0, 16'h0000, 16'd0);
      out_ready = 1'b1;
      step();
      chk("fl_after.out_valid", {15'd0, out_valid}, 16'd0);

      // Flush while in_ready=1 still blocks the offered input.
      offer(1'b1, 16'h6677, 16'd23);
      flush = 1'b1;
      step();
      flush = 1'b0;
      offer(1'b0, 16'h0000, 16'd0);
      chk("fl_rdy.out_valid", {15'd0, out_valid}, 16'd0);

      // Simultaneous consume and accept: no bubble, skid stays empty.
      offer(1'b1, 16'h7777, 16'd30);
      step();
      chk("cc_h.out_inst", out_inst, 16'h7777);
      offer(1'b1, 16'h8888, 16'd31);
      step();
      chk_out("cc_i", 16'h8888, 16'd31, 4'h8, 4'h8, 4'h8, 4'h8, 16'hFF88);
      chk("cc_i.in_ready", {15'd0, in_ready}, 16'd1);

      // Asynchronous reset mid-cycle with both slots occupied.
      out_ready = 1'b0;
      offer(1'b1, 16'h9999, 16'd32);
      step();
      chk("rs_pre.in_ready", {15'd0, in_ready}, 16'd0);
      offer(1'b0, 16'h0000, 16'd0);
      #2;
      rst = 1'b1;
      #1;
      chk_idle_reset("async_rst");
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      offer(1'b1, 16'h0123, 16'd40);
      step();
      chk_out("rs_post", 16'h0123, 16'd40, 4'h0, 4'h1, 4'h2, 4'h3, 16'h0023);

      // Sign-extension boundary.
      offer(1'b1, 16'h007F, 16'd41);
      step();
      chk_out("sx_7f", 16'h007F, 16'd41, 4'h0, 4'h0, 4'h7, 4'hF, 16'h007F);
      offer(1'b1, 16'h0080, 16'd42);
      step();
      chk_out("sx_80", 16'h0080, 16'd42, 4'h0, 4'h0, 4'h8, 4'h0, 16'hFF80);
      offer(1'b0, 16'h0000, 16'd0);
      step();
      chk("end.out_valid", {15'd0, out_valid}, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
